fifo_spram_pingpong: RTL
========================

# fifo_spram_pingpong

Synchronous FIFO that stores its data in two internal single-port RAM banks, even entries in bank 0 and odd entries in bank 1, so that one write and one read can proceed in the same cycle. It is the parametrised successor to our single-bank single-port FIFO storage. The single-bank design defers a colliding write by one cycle. This block removes that stall by ping-ponging across banks, and adds a valid/ready interface on both sides, a first-word-fall-through output stage, occupancy count and flags. It sits between producer and consumer pipeline stages wherever dual-port RAM is unavailable.

## Interface
- DATA_WIDTH, 8, payload width in bits
- FIFO_DEPTH, 16, total entries; power of two, ≥4; each bank holds FIFO_DEPTH/2
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserts when count ≥ this value
- ADDR_WIDTH, $clog2(FIFO_DEPTH), derived; do not override
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  producer has data
- wr_ready  out  1  FIFO can accept; equals count < FIFO_DEPTH
- wr_data  in  DATA_WIDTH  write payload
- rd_valid  out  1  rd_data holds the oldest entry
- rd_ready  in  1  consumer takes rd_data
- rd_data  out  DATA_WIDTH  head entry, registered
- count  out  ADDR_WIDTH+1  entries accepted and not yet popped
- full  out  1  count == FIFO_DEPTH
- almost_full  out  1  count ≥ AFULL_THRESH
- empty  out  1  count == 0

## Operation
- A push occurs on wr_valid & wr_ready. A pop occurs on rd_valid & rd_ready.
- The write pointer wptr[ADDR_WIDTH-1:0] selects the bank with wptr[0] and the row with wptr[ADDR_WIDTH-1:1]. It increments per push and wraps modulo FIFO_DEPTH.
- The memory read pointer mptr uses the same bank/row split. It increments per issued prefetch read.
- Each bank is single-port and services one read or one write per cycle. Read latency is 1 cycle; read data is valid the cycle after the request.
- The output stage is a 2-entry register FIFO. rd_data and rd_valid come from its head.
- A prefetch read is issued when memory holds ≥1 unread entry and (output-stage occupancy + reads in flight) < 2.
- Bank conflict: a push and a prefetch target the same bank in the same cycle. The write wins and the read is deferred to the next cycle. Because consecutive pushes alternate banks, the deferred read always proceeds next cycle, so there is no starvation.
- count is +1 on a push, −1 on a pop, and unchanged when both occur. Stored data never exceeds FIFO_DEPTH, so the memory cannot overflow.
- empty can be 0 while rd_valid is 0, because data may be in memory or in flight.
- Memory contents are not reset and are not X-checked until written.

## Timing
- Reset values: wr_ready=1, rd_valid=0, rd_data=0, count=0, full=0, almost_full=0, empty=1. All pointers, the in-flight flag and the output stage are cleared.
- Reset asserted mid-operation discards all contents immediately. The first push after release is accepted in the first cycle with rst_n high.
- Latency: a push in cycle N into an empty FIFO gives rd_valid=1 in cycle N+3 (prefetch N+1, RAM data N+2, output register N+3).
- wr_ready, full, almost_full and empty are registered from count. They update the cycle after the push or pop that changes count.
- Full: with count==FIFO_DEPTH, a push is refused. If a pop and a push attempt occur in the same cycle, the push is still refused that cycle, because wr_ready is derived from the current count.
- Empty: a pop is impossible because rd_valid=0. rd_data holds its last value.
- Throughput: with wr_valid=rd_ready=1 continuously, steady state is 1 push and 1 pop per cycle. Conflicts self-resolve because one deferred read makes the memory occupancy odd, which places the write and read pointers in opposite banks.
- rd_data must stay stable while rd_valid=1 and rd_ready=0.

## Test plan
- Reset, then push 0x01..0x03 on consecutive cycles with rd_ready=0 -> rd_valid rises 3 cycles after the first push, rd_data=0x01, count=3, empty=0.
- Push 16 values 0x10..0x1F with rd_ready=0 (FIFO_DEPTH=16) -> full=1 and wr_ready=0 after the 16th push, almost_full=1 after the 14th; a 17th wr_valid is not accepted; then draining yields 0x10..0x1F in order.
- Continuous push/pop for 200 cycles with an incrementing pattern -> no loss or reorder, and after the initial fill exactly one pop per cycle.
- Random wr_valid/rd_ready at 50% each for 5000 cycles with a scoreboard -> in-order data, count matches the model, the pointers wrap at least 10 times, and rd_data is stable while stalled.
- Hold rd_ready=0 with rd_valid=1 and data 0xA5 for 5 cycles while pushing -> rd_data stays 0xA5, count increments per push.
- Assert rst_n=0 for one cycle while count=7 -> all outputs return to reset values asynchronously, and after release a push of 0x3C appears at rd_data 3 cycles later.

Source files
------------

// File: rtl/fifo_spram_pingpong.sv
// Synchronous FIFO over two single-port RAM banks (even/odd entries) with a
// 2-entry first-word-fall-through output stage, occupancy count and flags.
module fifo_spram_pingpong #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned AFULL_THRESH = FIFO_DEPTH - 2,
  localparam int unsigned ADDR_WIDTH  = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty
);

  localparam int unsigned PW   = ADDR_WIDTH + 1;
  localparam int unsigned ROWS = FIFO_DEPTH / 2;

  // Pointers carry one extra wrap bit so their difference is the unread level
  logic [PW-1:0]         wptr_q, mptr_q;
  logic [PW-1:0]         unread_c, count_nxt_c;
  logic                  push_c, pop_c, conflict_c, rd_issue_c, cap_slot0_c;
  logic [2:0]            budget_c;
  logic [1:0]            os_cnt_q, os_cnt_nxt_c;
  logic                  inflight_q, inflight_bank_q;
  logic [DATA_WIDTH-1:0] os1_q, bank0_q, bank1_q, ram_q_c;
  logic [DATA_WIDTH-1:0] bank0_mem [ROWS];
  logic [DATA_WIDTH-1:0] bank1_mem [ROWS];

  // Handshakes, prefetch decision and next-state occupancy
  always_comb begin
    push_c      = wr_valid & wr_ready;
    pop_c       = rd_valid & rd_ready;
    unread_c    = wptr_q - mptr_q;
    conflict_c  = push_c && (wptr_q[0] == mptr_q[0]);
    // Output-stage slots committed after this cycle's pop, plus the read in flight
    budget_c    = {1'b0, os_cnt_q} + 3'(inflight_q) - 3'(pop_c);
    rd_issue_c  = (unread_c != '0) && (budget_c < 3'd2) && !conflict_c;
    count_nxt_c = count + PW'(push_c) - PW'(pop_c);
    os_cnt_nxt_c = os_cnt_q + 2'(inflight_q) - 2'(pop_c);
    cap_slot0_c = (os_cnt_q == 2'd0) || ((os_cnt_q == 2'd1) && pop_c);
    ram_q_c     = inflight_bank_q ? bank1_q : bank0_q;
  end

  // Bank 0: single port, write has priority over the prefetch read
  always_ff @(posedge clk) begin
    if (push_c && !wptr_q[0])
      bank0_mem[wptr_q[ADDR_WIDTH-1:1]] <= wr_data;
    else if (rd_issue_c && !mptr_q[0])
      bank0_q <= bank0_mem[mptr_q[ADDR_WIDTH-1:1]];
  end

  // Bank 1: same arrangement for odd entries
  always_ff @(posedge clk) begin
    if (push_c && wptr_q[0])
      bank1_mem[wptr_q[ADDR_WIDTH-1:1]] <= wr_data;
    else if (rd_issue_c && mptr_q[0])
      bank1_q <= bank1_mem[mptr_q[ADDR_WIDTH-1:1]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q          <= '0;
      mptr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_bank_q <= 1'b0;
      os_cnt_q        <= 2'd0;
      os1_q           <= '0;
      rd_data         <= '0;
      rd_valid        <= 1'b0;
      count           <= '0;
      wr_ready        <= 1'b1;
      full            <= 1'b0;
      almost_full     <= 1'b0;
      empty           <= 1'b1;
    end else begin
      wptr_q          <= wptr_q + PW'(push_c);
      mptr_q          <= mptr_q + PW'(rd_issue_c);
      inflight_q      <= rd_issue_c;
      inflight_bank_q <= mptr_q[0];
      os_cnt_q        <= os_cnt_nxt_c;
      rd_valid        <= (os_cnt_nxt_c != 2'd0);
      // Pop shifts the second slot forward; RAM data lands in the first free slot
      if (pop_c && (os_cnt_q == 2'd2))
        rd_data <= os1_q;
      if (inflight_q) begin
        if (cap_slot0_c) rd_data <= ram_q_c;
        else             os1_q   <= ram_q_c;
      end
      count       <= count_nxt_c;
      wr_ready    <= (count_nxt_c < PW'(FIFO_DEPTH));
      full        <= (count_nxt_c == PW'(FIFO_DEPTH));
      almost_full <= (count_nxt_c >= PW'(AFULL_THRESH));
      empty       <= (count_nxt_c == '0);
    end
  end

endmodule
